// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, frame capture, E0/F0 prefix decode, event FIFO.
// Optional LED counter when PS2_RX_LED_EN is defined.
module ps2_rx_decoder #(
  parameter int CLK_DIV       = 250,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FILT_LEN      = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_rel,
  output logic       frame_err,
  output logic       ovf
`ifdef PS2_RX_LED_EN
  ,
  output logic [7:0] led
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int FL_W  = $clog2(FILT_LEN + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [DIV_W-1:0] div_reg;
  logic             tick;
  logic [1:0]       clk_sync_reg, data_sync_reg;
  logic             filt_reg;
  logic [FL_W-1:0]  filt_cnt_reg;
  logic             filt_flip, fall;

  assign tick = (div_reg == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg       <= '0;
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      div_reg       <= tick ? '0 : div_reg + 1'b1;
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  // The filtered clock flips on the FILT_LEN-th consecutive differing sample.
  assign filt_flip = tick && (clk_sync_reg[1] != filt_reg) &&
                     (filt_cnt_reg == FL_W'(FILT_LEN - 1));
  assign fall      = filt_flip && filt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (tick) begin
      if (clk_sync_reg[1] == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_flip) begin
        filt_reg     <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  state_t           state_reg, state_next;
  logic [10:0]      shift_reg, shift_next;
  logic [3:0]       bit_cnt_reg, bit_cnt_next;
  logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
  logic             ext_reg, ext_next, rel_reg, rel_next;
  logic             frame_err_next, push_req, frame_ok;
  logic [7:0]       code;

  assign code     = shift_reg[8:1];
  assign frame_ok = !shift_reg[0] && shift_reg[10] && (^shift_reg[9:1]);

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    to_cnt_next    = to_cnt_reg;
    ext_next       = ext_reg;
    rel_next       = rel_reg;
    frame_err_next = 1'b0;
    push_req       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fall) begin
          shift_next   = {data_sync_reg[1], shift_reg[10:1]};
          bit_cnt_next = 4'd1;
          to_cnt_next  = '0;
          state_next   = RECV;
        end
      end
      RECV: begin
        if (fall) begin
          shift_next   = {data_sync_reg[1], shift_reg[10:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          to_cnt_next  = '0;
          if (bit_cnt_reg == 4'd10) state_next = CHECK;
        end else if (to_cnt_reg == TO_W'(TIMEOUT_TICKS)) begin
          state_next     = IDLE;
          bit_cnt_next   = '0;
          frame_err_next = 1'b1;
        end else if (tick) begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      CHECK: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
        if (!frame_ok) begin
          frame_err_next = 1'b1;
          ext_next       = 1'b0;
          rel_next       = 1'b0;
        end else if (code == 8'hE0) begin
          ext_next = 1'b1;
        end else if (code == 8'hF0) begin
          rel_next = 1'b1;
        end else begin
          push_req = 1'b1;
          ext_next = 1'b0;
          rel_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        empty, full, pop, push_ok, ovf_next;
  logic [9:0]  head;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = ((wr_ptr_reg - rd_ptr_reg) == (AW+1)'(FIFO_DEPTH));
  assign pop      = !empty && evt_ready;
  // A pop in the same cycle frees the slot, so a push on full is still accepted.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_next = push_req && full && !pop;
  assign head     = mem[rd_ptr_reg[AW-1:0]];

  assign evt_valid = !empty;
  assign evt_code  = empty ? 8'h00 : head[9:2];
  assign evt_ext   = !empty && head[1];
  assign evt_rel   = !empty && head[0];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= {code, ext_reg, rel_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      ext_reg     <= 1'b0;
      rel_reg     <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      frame_err   <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      ext_reg     <= ext_next;
      rel_reg     <= rel_next;
      frame_err   <= frame_err_next;
      ovf         <= ovf_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

`ifdef PS2_RX_LED_EN
  // Counts on every decoded press, even when the FIFO drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 8'h00;
    end else if (push_req && !rel_reg) begin
      if (code == 8'h75)      led <= led + 8'd1;
      else if (code == 8'h72) led <= led - 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: PS/2 frames driven on the pins, events and pulses checked.
module tb_ps2_rx_decoder;
  localparam int CLK_DIV = 4;
  localparam int TO_TICKS = 40;
  localparam int FILT = 3;
  localparam int DEPTH = 4;
  localparam int HALF = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic evt_ready = 1'b0;
  logic evt_valid, evt_ext, evt_rel, frame_err, ovf;
  logic [7:0] evt_code;
`ifdef PS2_RX_LED_EN
  logic [7:0] led;
`endif

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ovf_cnt = 0;

  ps2_rx_decoder #(
    .CLK_DIV(CLK_DIV), .TIMEOUT_TICKS(TO_TICKS), .FILT_LEN(FILT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_rel(evt_rel), .frame_err(frame_err), .ovf(ovf)
`ifdef PS2_RX_LED_EN
    , .led(led)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (ovf) ovf_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clks(HALF / 2);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
    wait_clks(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic par_flip, input logic stop);
    logic par;
    par = ~(^code) ^ par_flip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic send_code(input logic [7:0] code);
    send_frame(code, 1'b0, 1'b1);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] code, input logic ext, input logic rel);
    chk({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
    chk({tag, "_code"}, {24'd0, evt_code}, {24'd0, code});
    chk({tag, "_ext"}, {31'd0, evt_ext}, {31'd0, ext});
    chk({tag, "_rel"}, {31'd0, evt_rel}, {31'd0, rel});
    evt_ready = 1'b1;
    wait_clks(1);
    evt_ready = 1'b0;
  endtask

  initial begin
    wait_clks(5);
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_code", {24'd0, evt_code}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    wait_clks(5);

    // Plain frame
    send_code(8'h1C);
    pop_check("ev1c", 8'h1C, 1'b0, 1'b0);
    chk("ev1c_empty", {31'd0, evt_valid}, 32'd0);
    chk("ev1c_ferr", fe_cnt, 32'd0);

    // Extended release, then plain press of same code
    send_code(8'hE0);
    send_code(8'hF0);
    chk("pfx_noevt", {31'd0, evt_valid}, 32'd0);
    send_code(8'h75);
    pop_check("e0f075", 8'h75, 1'b1, 1'b1);
    chk("e0f075_single", {31'd0, evt_valid}, 32'd0);
    send_code(8'h75);
    pop_check("plain75", 8'h75, 1'b0, 1'b0);

    // Parity error
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("par_ferr", fe_cnt, 32'd1);
    chk("par_noevt", {31'd0, evt_valid}, 32'd0);

    // E0 cleared by bad-stop frame
    send_code(8'hE0);
    send_frame(8'h12, 1'b0, 1'b0);
    chk("stop_ferr", fe_cnt, 32'd2);
    send_code(8'h74);
    pop_check("ev74", 8'h74, 1'b0, 1'b0);

    // Timeout after 6 bits
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    wait_clks(100 * CLK_DIV);
    chk("to_ferr", fe_cnt, 32'd3);
    chk("to_noevt", {31'd0, evt_valid}, 32'd0);
    send_code(8'h29);
    pop_check("ev29", 8'h29, 1'b0, 1'b0);

    // Reset mid-frame drops the partial frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);
    send_code(8'h4B);
    pop_check("ev4b", 8'h4B, 1'b0, 1'b0);
    chk("rstmid_ferr", fe_cnt, 32'd3);

    // Overflow: DEPTH+1 codes without popping
    for (int i = 0; i < DEPTH; i++) send_code(8'h11 + 8'(i));
    chk("fill_ovf", ovf_cnt, 32'd0);
    send_code(8'h15);
    chk("ovf_pulse", ovf_cnt, 32'd1);
    pop_check("q0", 8'h11, 1'b0, 1'b0);
    pop_check("q1", 8'h12, 1'b0, 1'b0);
    pop_check("q2", 8'h13, 1'b0, 1'b0);
    pop_check("q3", 8'h14, 1'b0, 1'b0);
    chk("q_empty", {31'd0, evt_valid}, 32'd0);

    // Short low glitch on ps2_clk must not shift a bit
    ps2_clk = 1'b0;
    wait_clks((FILT - 1) * CLK_DIV);
    ps2_clk = 1'b1;
    wait_clks(2 * HALF);
    send_code(8'h5A);
    pop_check("glitch5a", 8'h5A, 1'b0, 1'b0);
    chk("glitch_ferr", fe_cnt, 32'd3);

`ifdef PS2_RX_LED_EN
    rst_n = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(2);
    chk("led_rst", {24'd0, led}, 32'd0);
    send_code(8'h75);
    chk("led_1", {24'd0, led}, 32'd1);
    send_code(8'h75);
    chk("led_2", {24'd0, led}, 32'd2);
    send_code(8'hF0);
    send_code(8'h75);
    chk("led_rel", {24'd0, led}, 32'd2);
    send_code(8'h72);
    chk("led_dec", {24'd0, led}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
